// File: rtl/ceres_clint.sv
// Core-Local Interruptor: per-hart mtimecmp/msip, shared prescaled mtime,
// byte-strobed register bus with one-cycle registered responses.
module ceres_clint #(
  parameter int unsigned NUM_HARTS    = 1,
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [15:0]          req_addr_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 res_valid_o,
  output logic [31:0]          res_rdata_o,
  output logic                 res_err_o,
  input  logic                 halt_i,
  output logic [63:0]          mtime_o,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [63:0]          mtime;
  logic [15:0]          presc;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic [NUM_HARTS-1:0] mtip;

  logic        in_msip, in_cmp, in_mtime, hit, err, wr, hi_word, tick, mtime_wr;
  logic [31:0] msip_idx, cmp_idx, rdata;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    for (int unsigned b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  // Address decode: msip words below 0x4000, mtimecmp pairs up to 0xBFF7, mtime at 0xBFF8.
  always_comb begin
    in_msip  = (req_addr_i[15:14] == 2'b00);
    in_cmp   = (req_addr_i >= 16'h4000) && (req_addr_i < 16'hBFF8);
    in_mtime = (req_addr_i[15:3] == 13'h17FF);
    msip_idx = 32'(req_addr_i[13:2]);
    cmp_idx  = 32'(req_addr_i - 16'h4000) >> 3;
    hi_word  = req_addr_i[2];
    hit      = (in_msip && (msip_idx < NUM_HARTS)) ||
               (in_cmp && (cmp_idx < NUM_HARTS)) || in_mtime;
    err      = (req_addr_i[1:0] != 2'b00) || !hit;
    wr       = req_valid_i && !err && (req_wstrb_i != 4'b0000);
    mtime_wr = wr && in_mtime;
    tick     = !halt_i && (presc == PRESC_MAX);
  end

  always_comb begin
    rdata = '0;
    if (!err && (req_wstrb_i == 4'b0000)) begin
      if (in_mtime) begin
        rdata = hi_word ? mtime[63:32] : mtime[31:0];
      end else begin
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
          if (in_msip && (msip_idx == h)) rdata = {31'b0, msip[h]};
          if (in_cmp && (cmp_idx == h))
            rdata = hi_word ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime       <= '0;
      presc       <= '0;
      msip        <= '0;
      mtip        <= '0;
      res_valid_o <= 1'b0;
      res_err_o   <= 1'b0;
      res_rdata_o <= '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= MTIMECMP_RST;
    end else begin
      res_valid_o <= req_valid_i;
      res_err_o   <= req_valid_i && err;
      res_rdata_o <= req_valid_i ? rdata : '0;

      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        mtip[h] <= (mtime >= mtimecmp[h]);
        if (wr && in_msip && (msip_idx == h) && req_wstrb_i[0]) msip[h] <= req_wdata_i[0];
        if (wr && in_cmp && (cmp_idx == h)) begin
          if (hi_word)
            mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], req_wdata_i, req_wstrb_i);
          else
            mtimecmp[h][31:0]  <= merge(mtimecmp[h][31:0], req_wdata_i, req_wstrb_i);
        end
      end

      // A software write to mtime overrides the tick and restarts the prescaler.
      if (mtime_wr) begin
        presc <= '0;
        if (hi_word) mtime[63:32] <= merge(mtime[63:32], req_wdata_i, req_wstrb_i);
        else         mtime[31:0]  <= merge(mtime[31:0], req_wdata_i, req_wstrb_i);
      end else if (!halt_i) begin
        presc <= tick ? '0 : presc + 16'd1;
        if (tick) mtime <= mtime + 64'd1;
      end
    end
  end

  assign req_ready_o = 1'b1;
  assign mtime_o     = mtime;
  assign mtip_o      = mtip;
  assign msip_o      = msip;

endmodule

// File: tb/tb_ceres_clint.sv
// Directed + randomized bench for ceres_clint; mtime is modelled as
// base + enabled_cycles_since_write / TICK_DIV.
module tb_ceres_clint;
  localparam int unsigned NH = 2;
  localparam int unsigned TD = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [15:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          res_valid;
  logic [31:0]   res_rdata;
  logic          res_err;
  logic          halt = 1'b0;
  logic [63:0]   mtime;
  logic [NH-1:0] mtip;
  logic [NH-1:0] msip;

  always #5 clk = ~clk;

  ceres_clint #(
    .NUM_HARTS   (NH),
    .TICK_DIV    (TD),
    .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .res_valid_o(res_valid),
    .res_rdata_o(res_rdata),
    .res_err_o  (res_err),
    .halt_i     (halt),
    .mtime_o    (mtime),
    .mtip_o     (mtip),
    .msip_o     (msip)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0]     m_base;
  longint unsigned m_en;
  logic [63:0]     m_cmp [NH];
  logic [NH-1:0]   m_msip, m_mtip;
  logic            e_valid, e_err;
  logic [31:0]     e_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_time();
    return m_base + 64'(m_en / TD);
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_base = '0;
    m_en   = 0;
    for (int h = 0; h < NH; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip  = '0;
    m_mtip  = '0;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_rdata = '0;
  endtask

  // One clock: predict from pre-edge state, advance, then compare all outputs.
  task automatic cycle();
    logic [63:0]   now;
    logic [NH-1:0] mtip_n;
    int unsigned   a, idx, kind;
    bit            bad, hi, is_wr, wrote_time;
    logic [31:0]   rd;
    now = m_time();
    for (int h = 0; h < NH; h++) mtip_n[h] = (now >= m_cmp[h]);
    a = 32'(req_addr);
    hi = req_addr[2];
    bad = 0; idx = 0; kind = 3;
    if (a < 32'h4000) begin kind = 0; idx = a / 4; end
    else if (a < 32'hBFF8) begin kind = 1; idx = (a - 32'h4000) / 8; end
    else if (a < 32'hC000) kind = 2;
    else bad = 1;
    if (a % 4 != 0) bad = 1;
    if ((kind == 0 || kind == 1) && idx >= NH) bad = 1;
    rd = '0;
    if (!bad) begin
      case (kind)
        0: rd = {31'b0, m_msip[idx]};
        1: rd = hi ? m_cmp[idx][63:32] : m_cmp[idx][31:0];
        2: rd = hi ? now[63:32] : now[31:0];
        default: rd = '0;
      endcase
    end
    is_wr = (req_wstrb != 4'b0000);
    e_valid = req_valid;
    e_err   = req_valid && bad;
    e_rdata = (req_valid && !bad && !is_wr) ? rd : '0;
    wrote_time = 0;
    if (req_valid && !bad && is_wr) begin
      case (kind)
        0: if (req_wstrb[0]) m_msip[idx] = req_wdata[0];
        1: if (hi) m_cmp[idx][63:32] = bmerge(m_cmp[idx][63:32], req_wdata, req_wstrb);
           else    m_cmp[idx][31:0]  = bmerge(m_cmp[idx][31:0], req_wdata, req_wstrb);
        2: begin
          if (hi) now[63:32] = bmerge(now[63:32], req_wdata, req_wstrb);
          else    now[31:0]  = bmerge(now[31:0], req_wdata, req_wstrb);
          m_base = now;
          m_en = 0;
          wrote_time = 1;
        end
        default: ;
      endcase
    end
    if (!wrote_time && !halt) m_en++;
    m_mtip = mtip_n;
    @(posedge clk);
    #1;
    chk("mtime", mtime, m_time());
    chk("mtip", 64'(mtip), 64'(m_mtip));
    chk("msip", 64'(msip), 64'(m_msip));
    chk("res_valid", 64'(res_valid), 64'(e_valid));
    chk("res_err", 64'(res_err), 64'(e_err));
    chk("res_rdata", 64'(res_rdata), 64'(e_rdata));
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_wstrb = '0;
    repeat (n) cycle();
  endtask

  task automatic access(input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] st);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = st;
    cycle();
    req_valid = 1'b0;
    req_wstrb = '0;
  endtask

  logic [15:0] addr_tab [11] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                                 16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'hC000};

  initial begin
    int waited;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_mtip", 64'(mtip), 64'd0);
    chk("rst_msip", 64'(msip), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("ready", 64'(req_ready), 64'd1);
    rst_ni = 1'b1;

    idle(40);
    chk("mtime_40", mtime, 64'd10);
    halt = 1'b1;
    idle(8);
    chk("mtime_halt", mtime, 64'd10);
    halt = 1'b0;
    idle(8);
    chk("mtime_resume", mtime, 64'd12);

    access(16'h4000, '0, 4'h0);
    chk("cmp0_lo_rst", 64'(res_rdata), 64'hFFFF_FFFF);
    access(16'h4004, '0, 4'h0);
    chk("cmp0_hi_rst", 64'(res_rdata), 64'hFFFF_FFFF);
    chk("cmp0_hi_err", 64'(res_err), 64'd0);

    access(16'hBFF8, 32'h10, 4'hF);
    access(16'hBFFC, 32'h0, 4'hF);
    access(16'h4008, 32'h20, 4'hF);
    access(16'h400C, 32'h0, 4'hF);
    waited = 0;
    while (!mtip[1] && waited < 100) begin
      idle(1);
      waited++;
    end
    chk("mtip1_rise", 64'(mtip), 64'b10);
    chk("mtime_at_rise", mtime, 64'h20);
    access(16'h400C, 32'h1, 4'hF);
    idle(1);
    chk("mtip1_fall", 64'(mtip[1]), 64'd0);

    access(16'h0004, 32'h1, 4'b0001);
    chk("msip_set", 64'(msip), 64'b10);
    access(16'h0004, 32'h0, 4'b0010);
    chk("msip_keep", 64'(msip), 64'b10);

    access(16'h4000, 32'h1, 4'hF);
    access(16'h4004, 32'h0, 4'hF);
    access(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    access(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    chk("mtime_set", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(2);
    chk("mtip0_high", 64'(mtip[0]), 64'd1);
    idle(6);
    chk("mtime_wrap", mtime, 64'd0);
    idle(1);
    chk("mtip0_drop", 64'(mtip[0]), 64'd0);

    access(16'h0002, '0, 4'h0);
    chk("err_misalign", {res_err, res_rdata}, {1'b1, 32'h0});
    access(16'h0008, '0, 4'h0);
    chk("err_hart", {res_err, res_rdata}, {1'b1, 32'h0});
    access(16'h8000, 32'hDEAD_BEEF, 4'hF);
    chk("err_unmapped", {res_err, res_rdata}, {1'b1, 32'h0});

    req_valid = 1'b1;
    req_wstrb = '0;
    req_addr  = 16'hBFF8;
    cycle();
    chk("b2b_first", 64'(res_valid), 64'd1);
    req_addr = 16'hBFFC;
    cycle();
    chk("b2b_second", 64'(res_valid), 64'd1);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom % 3) != 0;
      req_addr  = addr_tab[$urandom % 11];
      if ($urandom % 8 == 0) req_addr[1:0] = 2'($urandom_range(1, 3));
      req_wdata = $urandom;
      req_wstrb = ($urandom % 2) ? 4'h0 : 4'($urandom);
      halt      = ($urandom % 5) == 0;
      cycle();
    end
    halt = 1'b0;
    idle(2);

    req_valid = 1'b1;
    req_addr  = 16'h4000;
    req_wdata = 32'h1234_5678;
    req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wstrb = '0;
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_mtime", mtime, 64'd0);
    chk("mid_rst_msip", 64'(msip), 64'd0);
    chk("mid_rst_mtip", 64'(mtip), 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    access(16'h4000, '0, 4'h0);
    chk("mid_rst_cmp", 64'(res_rdata), 64'hFFFF_FFFF);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
